boc_acq_dop_sched: RTL and testbench
====================================

# boc_acq_dop_sched

Doppler-bin search scheduler for the B1 BOC acquisition engine. It steps the acquisition carrier NCO through a zig-zag set of Doppler bins around the nominal IF. For each bin it restarts the code-phase search engine, waits for the sweep result, and compares the result against a detection threshold. It reports the winning carrier FCW, code phase and peak to the tracking hand-off logic, or declares failure.

## Interface
- CAR_CENTER, 32'd1342177280: nominal carrier FCW (zero Doppler).
- DOP_STEP, 32'd268435: FCW increment per Doppler bin.
- NBINS, 21: number of bins searched; odd, range 1–63.
- CORR_WIDTH, 32: correlation peak width.
- PRN_PHS_WIDTH, 12: code-phase width.
- RST_CYC, 4: search-engine reset pulse length in cycles; range 1–15.
- TIMEOUT_CYC, 24'd8000000: per-bin dwell timeout in cycles.
- rx_clk in 1: sole clock; all logic is on its rising edge.
- rx_rst_n in 1: asynchronous, active-low reset.
- rx_start in 1: single-cycle pulse that starts a search; accepted only in IDLE, DONE or FAIL.
- rx_abort in 1: returns the block to IDLE from any state.
- rx_thresh in CORR_WIDTH: detection threshold, sampled on the start pulse.
- rx_sweep_done in 1: pulse from the search engine when a full code sweep completes.
- rx_peak in CORR_WIDTH: sweep maximum, valid with rx_sweep_done.
- rx_peak_phs in PRN_PHS_WIDTH: code phase of the sweep maximum, valid with rx_sweep_done.
- tx_car_fcw out 32: carrier FCW driven to the acquisition NCO.
- tx_srch_rst out 1: active-high reset to the search engine.
- tx_busy out 1: high in the RST and DWELL states.
- tx_acq_done out 1: level; high in DONE.
- tx_acq_fail out 1: level; high in FAIL.
- tx_best_fcw out 32: FCW of the winning bin.
- tx_best_phs out PRN_PHS_WIDTH: code phase of the winning bin.
- tx_best_peak out CORR_WIDTH: peak of the winning bin.
- tx_bin_idx out 6: index k of the current bin.

## Operation
- States are IDLE, RST, DWELL, EVAL, DONE and FAIL.
- Bin order: k=0 gives offset 0. Odd k gives +((k+1)/2)·DOP_STEP. Even k>0 gives −(k/2)·DOP_STEP.
  - tx_car_fcw = CAR_CENTER + offset, computed mod 2^32.
- IDLE/DONE/FAIL to RST on rx_start:
  - latch threshold;
  - set k=0;
  - clear best_peak to 0, best_phs to 0, best_fcw to CAR_CENTER;
  - clear done and fail.
- RST: tx_srch_rst is high for exactly RST_CYC cycles, then the block goes to DWELL. The dwell counter clears on entry to DWELL.
- DWELL: on rx_sweep_done, capture peak and phase and go to EVAL. If the counter reaches TIMEOUT_CYC first, treat the bin as peak=0 and go to EVAL.
- EVAL (one cycle): if peak > best_peak (strictly greater), update best_peak, best_phs and best_fcw. On a tie the earlier bin is kept.
- Next state from EVAL, full-sweep mode:
  - if k < NBINS−1: k+1, then RST;
  - else if best_peak ≥ threshold: DONE;
  - else: FAIL.
- rx_sweep_done outside DWELL is ignored.
- rx_start outside IDLE/DONE/FAIL is ignored.
- rx_abort has priority over every other event: the next state is IDLE, tx_srch_rst=1 for one cycle, and best_* results are held.

## Timing
- Reset values:
  - state IDLE, k=0;
  - tx_car_fcw=CAR_CENTER;
  - tx_srch_rst=1 (held high in IDLE);
  - tx_busy=0, tx_acq_done=0, tx_acq_fail=0;
  - tx_best_fcw=CAR_CENTER, tx_best_phs=0, tx_best_peak=0;
  - tx_bin_idx=0.
- All outputs are registered.
- tx_car_fcw and tx_bin_idx update in the same cycle that tx_srch_rst rises for a bin. The FCW is therefore stable for the full RST_CYC before the engine is released.
- Start to first tx_srch_rst deassertion: 1+RST_CYC cycles.
- rx_sweep_done to next bin's tx_srch_rst assertion: 2 cycles (DWELL→EVAL→RST).
- tx_acq_done and tx_acq_fail rise 2 cycles after the final rx_sweep_done.
- rx_sweep_done and timeout in the same cycle: the sweep result wins.

## Configuration
- ACQ_EARLY_EXIT_EN defined: in EVAL, if the captured peak ≥ threshold, the block updates best_* and goes straight to DONE, skipping the remaining bins. Otherwise it proceeds as in full-sweep mode.
- ACQ_EARLY_EXIT_EN undefined: all NBINS bins are always searched and the global maximum is reported.

## Test plan
- Reset with rx_rst_n=0 mid-DWELL: all outputs return to reset values asynchronously, tx_car_fcw=1342177280, and the block stays in IDLE after release.
- NBINS=5, model returns peak 10 on every bin: observe FCW sequence 1342177280, +268435, −268435, +536870, −536870. Threshold 5 gives DONE with tx_best_fcw=1342177280, the tie keeping bin 0.
- Peaks {3,9,4,12,7}, threshold 8, full sweep: DONE with tx_best_peak=12, tx_best_fcw=1342177280+536870, and tx_best_phs as supplied with bin 3. With ACQ_EARLY_EXIT_EN: DONE after bin 1 with peak 9.
- All peaks below threshold 100: tx_acq_fail=1 after bin 4. A following rx_start clears fail and restarts at k=0.
- Bin 2 never returns rx_sweep_done: the timeout is taken exactly TIMEOUT_CYC cycles after DWELL entry and the scheduler advances to bin 3.
- rx_abort during RST of bin 1, with a spurious rx_sweep_done and rx_start while busy: the block goes to IDLE the next cycle, tx_srch_rst is high, and the spurious inputs have no effect.

Source files
------------

// File: rtl/boc_acq_dop_sched.sv
// Zig-zag Doppler-bin scheduler for the B1 BOC acquisition engine.
// Optional ACQ_EARLY_EXIT_EN: stop at the first bin whose peak meets the threshold.
module boc_acq_dop_sched #(
  parameter logic [31:0] CAR_CENTER    = 32'd1342177280,
  parameter logic [31:0] DOP_STEP      = 32'd268435,
  parameter int          NBINS         = 21,
  parameter int          CORR_WIDTH    = 32,
  parameter int          PRN_PHS_WIDTH = 12,
  parameter int          RST_CYC       = 4,
  parameter logic [23:0] TIMEOUT_CYC   = 24'd8000000
) (
  input  logic                     rx_clk,
  input  logic                     rx_rst_n,
  input  logic                     rx_start,
  input  logic                     rx_abort,
  input  logic [CORR_WIDTH-1:0]    rx_thresh,
  input  logic                     rx_sweep_done,
  input  logic [CORR_WIDTH-1:0]    rx_peak,
  input  logic [PRN_PHS_WIDTH-1:0] rx_peak_phs,
  output logic [31:0]              tx_car_fcw,
  output logic                     tx_srch_rst,
  output logic                     tx_busy,
  output logic                     tx_acq_done,
  output logic                     tx_acq_fail,
  output logic [31:0]              tx_best_fcw,
  output logic [PRN_PHS_WIDTH-1:0] tx_best_phs,
  output logic [CORR_WIDTH-1:0]    tx_best_peak,
  output logic [5:0]               tx_bin_idx
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RST   = 3'd1;
  localparam logic [2:0] S_DWELL = 3'd2;
  localparam logic [2:0] S_EVAL  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_FAIL  = 3'd5;

  localparam logic [5:0]  LAST_BIN = 6'(NBINS - 1);
  localparam logic [23:0] RST_LAST = 24'(RST_CYC - 1);
  localparam logic [23:0] TO_LAST  = TIMEOUT_CYC - 24'd1;

  logic [2:0]               r_state;
  logic [23:0]              r_cnt;
  logic [5:0]               r_k;
  logic [CORR_WIDTH-1:0]    r_thresh;
  logic [CORR_WIDTH-1:0]    r_peak;
  logic [PRN_PHS_WIDTH-1:0] r_phs;
  logic [CORR_WIDTH-1:0]    r_best_peak;
  logic [PRN_PHS_WIDTH-1:0] r_best_phs;
  logic [31:0]              r_best_fcw;
  logic [31:0]              r_car_fcw;
  logic                     r_srch_rst;
  logic                     r_busy;
  logic                     r_done;
  logic                     r_fail;

  logic [2:0]            w_nxt;
  logic                  w_rst_end;
  logic                  w_tmo;
  logic                  w_last;
  logic                  w_better;
  logic                  w_early;
  logic [CORR_WIDTH-1:0] w_max;
  logic [5:0]            w_k_inc;

  // Odd bins step up, even bins step down, magnitude grows every two bins
  function automatic logic [31:0] bin_fcw(input logic [5:0] k);
    logic [31:0] mag;
    mag = ({26'd0, k} + 32'd1) >> 1;
    mag = mag * DOP_STEP;
    return k[0] ? CAR_CENTER + mag : CAR_CENTER - mag;
  endfunction

  assign w_rst_end = (r_cnt == RST_LAST);
  assign w_tmo     = (r_cnt == TO_LAST);
  assign w_last    = (r_k == LAST_BIN);
  assign w_better  = (r_peak > r_best_peak);
  assign w_max     = w_better ? r_peak : r_best_peak;
  assign w_k_inc   = r_k + 6'd1;

`ifdef ACQ_EARLY_EXIT_EN
  assign w_early = (r_peak >= r_thresh);
`else
  assign w_early = 1'b0;
`endif

  always_comb begin
    w_nxt = r_state;
    if (rx_abort) begin
      w_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_FAIL: begin
          if (rx_start) w_nxt = S_RST;
        end
        S_RST: begin
          if (w_rst_end) w_nxt = S_DWELL;
        end
        S_DWELL: begin
          if (rx_sweep_done || w_tmo) w_nxt = S_EVAL;
        end
        S_EVAL: begin
          if (w_early)
            w_nxt = S_DONE;
          else if (!w_last)
            w_nxt = S_RST;
          else if (w_max >= r_thresh)
            w_nxt = S_DONE;
          else
            w_nxt = S_FAIL;
        end
        default: w_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      r_state    <= S_IDLE;
      r_srch_rst <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_fail     <= 1'b0;
    end else begin
      r_state    <= w_nxt;
      r_srch_rst <= (w_nxt != S_DWELL) && (w_nxt != S_EVAL);
      r_busy     <= (w_nxt == S_RST) || (w_nxt == S_DWELL);
      r_done     <= (w_nxt == S_DONE);
      r_fail     <= (w_nxt == S_FAIL);
    end
  end

  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      r_cnt       <= '0;
      r_k         <= '0;
      r_thresh    <= '0;
      r_peak      <= '0;
      r_phs       <= '0;
      r_best_peak <= '0;
      r_best_phs  <= '0;
      r_best_fcw  <= CAR_CENTER;
      r_car_fcw   <= CAR_CENTER;
    end else if (!rx_abort) begin
      case (r_state)
        S_IDLE, S_DONE, S_FAIL: begin
          if (rx_start) begin
            r_thresh    <= rx_thresh;
            r_k         <= '0;
            r_car_fcw   <= CAR_CENTER;
            r_cnt       <= '0;
            r_best_peak <= '0;
            r_best_phs  <= '0;
            r_best_fcw  <= CAR_CENTER;
          end
        end
        S_RST: begin
          r_cnt <= w_rst_end ? 24'd0 : r_cnt + 24'd1;
        end
        S_DWELL: begin
          // A sweep result landing on the timeout cycle still wins
          if (rx_sweep_done) begin
            r_peak <= rx_peak;
            r_phs  <= rx_peak_phs;
          end else if (w_tmo) begin
            r_peak <= '0;
            r_phs  <= '0;
          end else begin
            r_cnt <= r_cnt + 24'd1;
          end
        end
        S_EVAL: begin
          if (w_better || w_early) begin
            r_best_peak <= r_peak;
            r_best_phs  <= r_phs;
            r_best_fcw  <= r_car_fcw;
          end
          if (w_nxt == S_RST) begin
            r_k       <= w_k_inc;
            r_car_fcw <= bin_fcw(w_k_inc);
            r_cnt     <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign tx_car_fcw   = r_car_fcw;
  assign tx_srch_rst  = r_srch_rst;
  assign tx_busy      = r_busy;
  assign tx_acq_done  = r_done;
  assign tx_acq_fail  = r_fail;
  assign tx_best_fcw  = r_best_fcw;
  assign tx_best_phs  = r_best_phs;
  assign tx_best_peak = r_best_peak;
  assign tx_bin_idx   = r_k;

endmodule

// File: tb/tb_boc_acq_dop_sched.sv
// Bench for boc_acq_dop_sched: table rows, random searches vs a bin-level model,
// plus abort and asynchronous-reset sequences.
`timescale 1ns/1ps
module tb_boc_acq_dop_sched;

  localparam int NB = 5;
  localparam int RC = 4;
  localparam int TO = 40;
  localparam logic [31:0] CAR = 32'd1342177280;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_start = 1'b0;
  logic        rx_abort = 1'b0;
  logic [31:0] rx_thresh = '0;
  logic        rx_sweep_done = 1'b0;
  logic [31:0] rx_peak = '0;
  logic [11:0] rx_peak_phs = '0;
  logic [31:0] tx_car_fcw;
  logic        tx_srch_rst;
  logic        tx_busy;
  logic        tx_acq_done;
  logic        tx_acq_fail;
  logic [31:0] tx_best_fcw;
  logic [11:0] tx_best_phs;
  logic [31:0] tx_best_peak;
  logic [5:0]  tx_bin_idx;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  boc_acq_dop_sched #(
    .NBINS(NB),
    .RST_CYC(RC),
    .TIMEOUT_CYC(24'd40)
  ) dut (
    .rx_clk(clk),
    .rx_rst_n(rst_n),
    .rx_start(rx_start),
    .rx_abort(rx_abort),
    .rx_thresh(rx_thresh),
    .rx_sweep_done(rx_sweep_done),
    .rx_peak(rx_peak),
    .rx_peak_phs(rx_peak_phs),
    .tx_car_fcw(tx_car_fcw),
    .tx_srch_rst(tx_srch_rst),
    .tx_busy(tx_busy),
    .tx_acq_done(tx_acq_done),
    .tx_acq_fail(tx_acq_fail),
    .tx_best_fcw(tx_best_fcw),
    .tx_best_phs(tx_best_phs),
    .tx_best_peak(tx_best_peak),
    .tx_bin_idx(tx_bin_idx)
  );

  // Zig-zag FCW sequence: 0, +1, -1, +2, -2 steps of 268435
  logic [31:0] fcw_tab [NB] = '{
    32'd1342177280, 32'd1342445715, 32'd1341908845,
    32'd1342714150, 32'd1341640410
  };

  typedef struct packed {
    logic [NB-1:0][7:0]  pk;
    logic [NB-1:0][11:0] ph;
    logic [NB-1:0]       to;
    logic [7:0]          th;
    logic                fs_done;
    logic [2:0]          fs_bin;
    logic                ee_done;
    logic [2:0]          ee_bin;
  } vec_t;

  vec_t tab [5];

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic set_row(input int i, input int p0, input int p1,
                         input int p2, input int p3, input int p4,
                         input logic [NB-1:0] to, input int th,
                         input bit fd, input int fb,
                         input bit ed, input int eb);
    int p [NB];
    p = '{p0, p1, p2, p3, p4};
    for (int k = 0; k < NB; k++) begin
      tab[i].pk[k] = 8'(p[k]);
      tab[i].ph[k] = 12'((i + 1) * 256 + k * 17 + 5);
    end
    tab[i].to = to;
    tab[i].th = 8'(th);
    tab[i].fs_done = fd;
    tab[i].fs_bin = 3'(fb);
    tab[i].ee_done = ed;
    tab[i].ee_bin = 3'(eb);
  endtask

  // Bin-level reference: strict-greater best, optional early exit
  function automatic void model(input logic [NB-1:0][7:0] pk,
                                input logic [NB-1:0] to, input int th,
                                output int nv, output bit dn,
                                output int bb);
    int best;
    best = 0;
    bb = -1;
    nv = NB;
    dn = 1'b0;
    for (int k = 0; k < NB; k++) begin
      int p;
      p = to[k] ? 0 : int'(pk[k]);
      if (p > best) begin
        best = p;
        bb = k;
      end
`ifdef ACQ_EARLY_EXIT_EN
      if (p >= th) begin
        bb = k;
        nv = k + 1;
        dn = 1'b1;
        return;
      end
`endif
    end
    dn = (best >= th);
  endfunction

  task automatic run_case(input string nm, input logic [NB-1:0][7:0] pk,
                          input logic [NB-1:0][11:0] ph,
                          input logic [NB-1:0] to, input logic [7:0] th,
                          input int nv, input bit dn, input int bb);
    int n;
    int d;
    @(negedge clk);
    rx_thresh = 32'(th);
    rx_start = 1'b1;
    @(negedge clk);
    rx_start = 1'b0;
    chk({nm, " clr"}, {tx_acq_done, tx_acq_fail}, 0);
    for (int k = 0; k < nv; k++) begin
      chk($sformatf("%s bin%0d idx", nm, k), tx_bin_idx, k);
      chk($sformatf("%s bin%0d fcw", nm, k), tx_car_fcw, fcw_tab[k]);
      chk($sformatf("%s bin%0d busy", nm, k), tx_busy, 1);
      n = 0;
      while (tx_srch_rst && n < 64) begin
        n++;
        @(negedge clk);
      end
      chk($sformatf("%s bin%0d rstlen", nm, k), n, RC);
      if (to[k]) begin
        n = 0;
        while (tx_busy && n < 4 * TO) begin
          n++;
          @(negedge clk);
        end
        chk($sformatf("%s bin%0d tmo", nm, k), n, TO);
      end else begin
        d = $urandom_range(0, 5);
        repeat (d) @(negedge clk);
        rx_sweep_done = 1'b1;
        rx_peak = 32'(pk[k]);
        rx_peak_phs = ph[k];
        @(negedge clk);
        rx_sweep_done = 1'b0;
        rx_peak = $urandom;
      end
      @(negedge clk);
    end
    chk({nm, " done"}, tx_acq_done, dn);
    chk({nm, " fail"}, tx_acq_fail, !dn);
    chk({nm, " busy_end"}, tx_busy, 0);
    if (bb < 0) begin
      chk({nm, " peak"}, tx_best_peak, 0);
      chk({nm, " phs"}, tx_best_phs, 0);
      chk({nm, " bfcw"}, tx_best_fcw, CAR);
    end else begin
      chk({nm, " peak"}, tx_best_peak, to[bb] ? 0 : pk[bb]);
      chk({nm, " phs"}, tx_best_phs, to[bb] ? 0 : ph[bb]);
      chk({nm, " bfcw"}, tx_best_fcw, fcw_tab[bb]);
    end
  endtask

  task automatic wait_release(input string nm);
    int n;
    n = 0;
    while (tx_srch_rst && n < 64) begin
      n++;
      @(negedge clk);
    end
    chk({nm, " rel"}, tx_srch_rst, 0);
  endtask

  task automatic check_reset_vals(input string nm);
    chk({nm, " fcw"}, tx_car_fcw, CAR);
    chk({nm, " srst"}, tx_srch_rst, 1);
    chk({nm, " busy"}, tx_busy, 0);
    chk({nm, " flags"}, {tx_acq_done, tx_acq_fail}, 0);
    chk({nm, " bfcw"}, tx_best_fcw, CAR);
    chk({nm, " bphs"}, tx_best_phs, 0);
    chk({nm, " bpeak"}, tx_best_peak, 0);
    chk({nm, " idx"}, tx_bin_idx, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    set_row(0, 10, 10, 10, 10, 10, 5'b00000, 5, 1, 0, 1, 0);
    set_row(1, 3, 9, 4, 12, 7, 5'b00000, 8, 1, 3, 1, 1);
    set_row(2, 1, 2, 3, 4, 5, 5'b00000, 100, 0, 4, 0, 4);
    set_row(3, 3, 5, 99, 7, 2, 5'b00100, 6, 1, 3, 1, 3);
    set_row(4, 2, 6, 6, 1, 3, 5'b00000, 6, 1, 1, 1, 1);

    #12;
    check_reset_vals("por");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle busy", tx_busy, 0);

    for (int r = 0; r < 5; r++) begin
      bit dn;
      int bb;
      int nv;
`ifdef ACQ_EARLY_EXIT_EN
      dn = tab[r].ee_done;
      bb = int'(tab[r].ee_bin);
      nv = dn ? bb + 1 : NB;
`else
      dn = tab[r].fs_done;
      bb = int'(tab[r].fs_bin);
      nv = NB;
`endif
      run_case($sformatf("row%0d", r), tab[r].pk, tab[r].ph,
               tab[r].to, tab[r].th, nv, dn, bb);
    end

    // Abort in bin 1 RST with spurious start/sweep pulses
    @(negedge clk);
    rx_thresh = 32'd200;
    rx_start = 1'b1;
    @(negedge clk);
    rx_start = 1'b0;
    wait_release("ab b0");
    rx_sweep_done = 1'b1;
    rx_peak = 32'd50;
    rx_peak_phs = 12'h123;
    @(negedge clk);
    rx_sweep_done = 1'b0;
    @(negedge clk);
    chk("ab idx1", tx_bin_idx, 1);
    rx_start = 1'b1;
    rx_sweep_done = 1'b1;
    rx_peak = 32'd999;
    rx_thresh = 32'd1;
    @(negedge clk);
    rx_start = 1'b0;
    rx_sweep_done = 1'b0;
    chk("ab spur idx", tx_bin_idx, 1);
    chk("ab spur srst", tx_srch_rst, 1);
    chk("ab spur busy", tx_busy, 1);
    rx_abort = 1'b1;
    rx_start = 1'b1;
    rx_sweep_done = 1'b1;
    @(negedge clk);
    rx_abort = 1'b0;
    rx_start = 1'b0;
    rx_sweep_done = 1'b0;
    chk("ab busy", tx_busy, 0);
    chk("ab srst", tx_srch_rst, 1);
    chk("ab flags", {tx_acq_done, tx_acq_fail}, 0);
    chk("ab bpeak", tx_best_peak, 50);
    chk("ab bphs", tx_best_phs, 12'h123);
    chk("ab bfcw", tx_best_fcw, CAR);
    repeat (3) @(negedge clk);
    chk("ab stay", {tx_busy, tx_srch_rst}, 1);

    for (int r = 0; r < 12; r++) begin
      logic [NB-1:0][7:0] pk;
      logic [NB-1:0][11:0] ph;
      logic [NB-1:0] to;
      int th;
      int nv;
      int bb;
      bit dn;
      for (int k = 0; k < NB; k++) begin
        pk[k] = 8'($urandom_range(0, 20));
        ph[k] = 12'($urandom);
        to[k] = ($urandom_range(0, 7) == 0);
      end
      th = $urandom_range(0, 25);
      model(pk, to, th, nv, dn, bb);
      run_case($sformatf("rnd%0d", r), pk, ph, to, 8'(th), nv, dn, bb);
    end

    // Asynchronous reset in bin 1 DWELL
    @(negedge clk);
    rx_thresh = 32'd200;
    rx_start = 1'b1;
    @(negedge clk);
    rx_start = 1'b0;
    wait_release("rd b0");
    rx_sweep_done = 1'b1;
    rx_peak = 32'd30;
    rx_peak_phs = 12'h0ab;
    @(negedge clk);
    rx_sweep_done = 1'b0;
    @(negedge clk);
    wait_release("rd b1");
    chk("rd pre", tx_best_peak, 30);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("rd async");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check_reset_vals("rd after");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
